// File: rtl/bufm_rd_seq.sv
// rtl/bufm_rd_seq.sv - strided read sequencer with 2-entry output FIFO for a PE constant buffer
//
// Turns a (base_addr, stride, num_words) command into a stream of bufferM read
// addresses, captures the registered read data one cycle later, and presents the
// words on a valid/ready interface with full backpressure.
//
// Optional feature macro: BUFM_RD_LAST_EN (adds out_last, a per-entry last tag).
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-low reset
//   start             command strobe, only honoured in IDLE
//   base_addr, stride first read address and per-word address increment
//   num_words         number of words to fetch (0 completes immediately)
//   busy, done        busy while not IDLE; done pulses one cycle on completion
//   rd_addr           read address to bufferM
//   buf_data          bufferM read data, valid one cycle after rd_addr
//   out_data/out_valid/out_ready  word stream to the PE datapath
//   out_last          (BUFM_RD_LAST_EN only) marks the final word of a command
module bufm_rd_seq #(
    parameter int addrLen = 10,
    parameter int dataLen = 32,
    parameter int cntLen  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addrLen-1:0] base_addr,
    input  logic [addrLen-1:0] stride,
    input  logic [cntLen-1:0]  num_words,
    output logic               busy,
    output logic               done,
    output logic [addrLen-1:0] rd_addr,
    input  logic [dataLen-1:0] buf_data,
    output logic [dataLen-1:0] out_data,
    output logic               out_valid,
`ifdef BUFM_RD_LAST_EN
    output logic               out_last,
`endif
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [addrLen-1:0] cur_addr;
    logic [addrLen-1:0] stride_q;
    logic [addrLen-1:0] rd_addr_q;
    logic [cntLen-1:0]  remaining;
    logic               inflight;

    logic [dataLen-1:0] fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_count;

`ifdef BUFM_RD_LAST_EN
    logic               fifo_last [2];
    logic               last_inflight;
`endif

    logic               push;
    logic               pop;
    logic [2:0]         occupancy;
    logic               credit;
    logic               issue;
    logic               load;
    logic               done_next;

    assign push      = inflight;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign busy      = (state != IDLE);

`ifdef BUFM_RD_LAST_EN
    assign out_last  = out_valid & fifo_last[rd_ptr];
`endif

    // Words already buffered plus the one in flight, less the one leaving this
    // cycle; issuing only below two keeps the 2-entry FIFO from overflowing.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign credit    = (occupancy < 3'd2);

    // The address is presented in the issue cycle itself so bufferM's registered
    // read lands exactly when inflight is set; otherwise the last address holds.
    assign rd_addr   = issue ? cur_addr : rd_addr_q;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (credit) begin
                    issue = 1'b1;
                    if (remaining == cntLen'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the cycle that empties the pipeline so done lands
                // the cycle after the final handshake.
                if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            cur_addr    <= '0;
            stride_q    <= '0;
            rd_addr_q   <= '0;
            remaining   <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
`ifdef BUFM_RD_LAST_EN
            fifo_last[0]  <= 1'b0;
            fifo_last[1]  <= 1'b0;
            last_inflight <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            done     <= done_next;
            inflight <= issue;
`ifdef BUFM_RD_LAST_EN
            last_inflight <= issue && (remaining == cntLen'(1));
`endif
            if (load) begin
                cur_addr  <= base_addr;
                stride_q  <= stride;
                remaining <= num_words;
            end else if (issue) begin
                cur_addr  <= cur_addr + stride_q;
                remaining <= remaining - cntLen'(1);
                rd_addr_q <= cur_addr;
            end

            if (push) begin
                fifo_mem[wr_ptr] <= buf_data;
`ifdef BUFM_RD_LAST_EN
                fifo_last[wr_ptr] <= last_inflight;
`endif
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && !pop && fifo_count == 2'd2))
                else $error("bufm_rd_seq: push into full FIFO");
        end
    end
`endif

endmodule

// File: doc/bufm_rd_seq.md
Name: bufm_rd_seq

Overview:
- Read sequencer in front of each PE's constant buffer (bufferM).
- Generates the buffer's read-address stream from a (base, stride, count) command.
- Absorbs the buffer's one-cycle registered read latency and presents the words to the PE datapath on a valid/ready interface with full backpressure.
- One instance per PE, between the PE control unit (command side) and bufferM plus the PE operand mux (data side).

Parameters:
- addrLen, 10, width of buffer read address
- dataLen, 32, width of buffer data word
- cntLen, 8, width of word-count field

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset; all state cleared on a rising clk edge while reset==0
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  addrLen  first read address
- stride  in  addrLen  address increment per word
- num_words  in  cntLen  words to fetch; 0 is legal
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle completion pulse
- rd_addr  out  addrLen  to bufferM rd_addr
- buf_data  in  dataLen  from bufferM data_out; valid 1 cycle after rd_addr is issued
- out_data  out  dataLen  word to PE
- out_valid  out  1  out_data valid
- out_ready  in  1  PE accepts word

Behaviour:
- Reset values: busy=0, done=0, rd_addr=0, out_valid=0, out_data=0. The FIFO is emptied, the in-flight flag is cleared, state=IDLE, and all counters are 0.
- Reset mid-operation aborts the command. No done is generated and no further out_valid is asserted.
- States:
  - IDLE: start=1 and num_words>0 latches base_addr, stride and num_words, then goes to RUN. start=1 and num_words==0 stays in IDLE and pulses done the next cycle. start=0 stays in IDLE.
  - RUN: issues one address per cycle whenever a credit is available.
    - Credit: fifo_count + inflight - pop < 2, where pop = out_valid & out_ready.
    - Issue: drive rd_addr = cur_addr, set inflight for the next cycle, cur_addr <= cur_addr + stride (mod 2^addrLen, wraps silently), remaining <= remaining - 1.
    - When remaining transitions to 0 (last issue), go to DRAIN.
  - DRAIN: no issue. When fifo_count==0, inflight==0 and no pending pop, go to IDLE. done=1 for exactly the cycle after the final out handshake.
- start while busy=1 is ignored; the latched command is unchanged.
- rd_addr holds its last value when not issuing. bufferM reads every cycle, but buf_data is captured only when the in-flight flag is set.
- Data path: 2-entry FIFO.
  - buf_data is pushed the cycle after an issue.
  - out_data/out_valid reflect the FIFO head.
  - Push and pop in the same cycle is legal. Count is unchanged, ordering is preserved.
  - The credit rule guarantees no overflow. Push on full is impossible by construction; if it occurs it is a design bug, flagged by a simulation-only assertion.
- Latency, with out_ready held high and start sampled at cycle 0:
  - cycle 1: rd_addr=base
  - cycle 2: buf_data valid
  - cycle 3: first out_valid
- Throughput 1 word/cycle sustained.
- out_data is stable while out_valid=1 and out_ready=0.
- done never coincides with out_valid of the same command.

Optional Feature:
- Macro BUFM_RD_LAST_EN.
- Defined: adds output port out_last (1 bit), high together with out_valid on the final word of a command. Each FIFO entry carries a last tag bit; out_last=0 when out_valid=0 and at reset.
- Undefined: no out_last port, no tag bit; all other behaviour identical.

Test Plan:
- Basic: base=0, stride=1, num_words=4, out_ready=1 -> rd_addr 0,1,2,3 on cycles 1-4; out_valid cycles 3-6 with data = bufferM[0..3] (for PE 1: 1,0,0,0); done at cycle 7; busy cycles 1-6.
- Backpressure: num_words=5, out_ready toggles 1,0,0,1,... -> exactly 5 handshakes, in-order data, no duplicates or drops, out_data stable during stalls, FIFO count never >2.
- Wrap: addrLen=10, base=1022, stride=3, num_words=3 -> rd_addr 1022, 1, 4.
- Zero count: start with num_words=0 -> busy stays 0, no rd issue, no out_valid, done=1 at cycle 1 only.
- Start while busy: second start at cycle 2 with num_words=9 during a 4-word command -> ignored; exactly 4 words, one done.
- Reset mid-op: reset=0 for one cycle after 2 of 6 words are delivered -> next cycle all outputs at reset values, no done; a fresh command then behaves per Basic.
